// File: rtl/pd_buffer_ctrl.sv
// Write/read sequencer for the packet identifier's circular receive buffer.
// Turns PIPE write strobes into byte-granular write addresses, tracks the
// read head and fill level, holds the active PCIe generation (changing it
// only after the buffer drains) and flushes everything when the link drops.
module pd_buffer_ctrl #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int DEPTH          = 64,
  localparam int AW            = $clog2(DEPTH),
  localparam int CW            = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          linkup,
  input  logic [2:0]    gen,
  input  logic          valid_pd,
  input  logic          rd_en,
  input  logic [2:0]    rd_bytes,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [2:0]    wr_bytes,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic [2:0]    gen_active,
  output logic          gen_busy,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    ACTIVE    = 2'd1,
    DRAIN     = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [2:0]    gen_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    w;           // bytes per PIPE beat for the latched generation
  logic [2:0]    r;           // bytes popped this cycle
  logic          rd_window, rd_valid, rd_accept;
  logic          wr_req, space_ok;
  logic [CW:0]   fill_after;  // one spare bit so a 64+4 sum cannot wrap
  logic [CW-1:0] count_next;

  // Beat width in bytes for the latched generation; unknown codes accept nothing.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    w = 3'd0;
    case (gen_active)
      3'd0:    w = 3'(GEN1_PIPEWIDTH / 8);
      3'd1:    w = 3'(GEN2_PIPEWIDTH / 8);
      3'd2:    w = 3'(GEN3_PIPEWIDTH / 8);
      3'd3:    w = 3'(GEN4_PIPEWIDTH / 8);
      3'd4:    w = 3'(GEN5_PIPEWIDTH / 8);
      default: w = 3'd0;
    endcase
  end

  // Read/write acceptance for the current cycle, decided before the edge.
  always_comb begin
    // A link drop in the same cycle takes precedence, so no pop is taken then.
    rd_window  = ((state == ACTIVE) || (state == DRAIN)) && linkup;
    rd_valid   = rd_en && (rd_bytes inside {[3'd1:3'd4]});
    rd_accept  = rd_window && rd_valid && ({{(CW-3){1'b0}}, rd_bytes} <= count);
    underflow  = rd_window && rd_valid && ({{(CW-3){1'b0}}, rd_bytes} > count);
    r          = rd_accept ? rd_bytes : 3'd0;

    // Space check credits the bytes a simultaneous pop frees up.
    fill_after = {1'b0, count} - (CW+1)'(r) + (CW+1)'(w);
    space_ok   = fill_after <= (CW+1)'(DEPTH);
    wr_req     = (state == ACTIVE) && valid_pd && linkup && (w != 3'd0);
    wr_en      = wr_req && space_ok;
    overflow   = wr_req && !space_ok;

    count_next = count - CW'(r) + (wr_en ? CW'(w) : '0);
  end

  // Next-state logic: gen changes wait for an empty buffer, link loss flushes.
  always_comb begin
    state_next = state;
    gen_next   = gen_active;
    case (state)
      LINK_DOWN: begin
        if (linkup) begin
          state_next = ACTIVE;
          gen_next   = gen;
        end
      end
      ACTIVE: begin
        if (!linkup)                 state_next = FLUSH;
        else if (gen != gen_active)  state_next = DRAIN;
      end
      DRAIN: begin
        if (!linkup) begin
          state_next = FLUSH;
        end else if (gen == gen_active) begin
          state_next = ACTIVE;
        end else if (count_next == '0) begin
          state_next = ACTIVE;
          gen_next   = gen;
        end
      end
      FLUSH:   state_next = LINK_DOWN;
      default: state_next = LINK_DOWN;
    endcase
  end

  // State, generation and pointer registers; entering or sitting in FLUSH clears the buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= LINK_DOWN;
      gen_active <= 3'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_next;
      gen_active <= gen_next;
      if ((state_next == FLUSH) || (state == FLUSH)) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + (wr_en ? AW'(w) : '0);
        rd_ptr <= rd_ptr + AW'(r);
        count  <= count_next;
      end
    end
  end

  assign wr_addr  = wr_ptr;
  assign wr_bytes = w;
  assign rd_addr  = rd_ptr;
  assign empty    = (count == '0);
  assign full     = {1'b0, count} > ((CW+1)'(DEPTH) - (CW+1)'(w));
  assign gen_busy = (state == DRAIN);

endmodule

// File: tb/tb_pd_buffer_ctrl.sv
// Self-checking bench for pd_buffer_ctrl: directed scenarios followed by
// randomized traffic, all compared against a byte-counting reference model.
module tb_pd_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst, linkup, valid_pd, rd_en;
  logic [2:0] gen, rd_bytes;
  logic       wr_en, empty, full, gen_busy, overflow, underflow;
  logic [5:0] wr_addr, rd_addr;
  logic [2:0] wr_bytes, gen_active;
  logic [6:0] count;

  pd_buffer_ctrl dut (
    .clk(clk), .rst(rst), .linkup(linkup), .gen(gen), .valid_pd(valid_pd),
    .rd_en(rd_en), .rd_bytes(rd_bytes), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_bytes(wr_bytes), .rd_addr(rd_addr), .count(count), .empty(empty),
    .full(full), .gen_active(gen_active), .gen_busy(gen_busy),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: total bytes ever written/read since the last clear, plus
  // link/drain/flush flags. Fill level and addresses follow by arithmetic.
  int written, readn, gact;
  bit up, drain, flush;
  // Pulses seen in the most recent step, for directed spot checks.
  bit last_of, last_uf;
  int last_wb;

  function automatic int width_of(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 1;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    written = 0; readn = 0; gact = 0;
    up = 0; drain = 0; flush = 0;
  endtask

  // One clock: drive inputs on the falling edge, check outputs, update model after the rising edge.
  task automatic step(input bit r, input bit lu, input int g, input bit v, input bit re, input int rb);
    int w_b, cnt, rr;
    bit act, dr, rdv, rs, uf, req, ok, we, of;
    @(negedge clk);
    rst = r; linkup = lu; gen = 3'(g); valid_pd = v; rd_en = re; rd_bytes = 3'(rb);
    #1;
    w_b = width_of(gact);
    cnt = written - readn;
    act = up && !drain;
    dr  = up && drain;
    rdv = re && (rb >= 1) && (rb <= 4);
    rs  = (act || dr) && lu;
    rr  = (rs && rdv && rb <= cnt) ? rb : 0;
    uf  = rs && rdv && (rb > cnt);
    req = act && v && lu && (w_b != 0);
    ok  = (cnt - rr + w_b) <= 64;
    we  = req && ok;
    of  = req && !ok;
    check("wr_en",      wr_en,      we);
    check("wr_addr",    wr_addr,    written % 64);
    check("wr_bytes",   wr_bytes,   w_b);
    check("rd_addr",    rd_addr,    readn % 64);
    check("count",      count,      cnt);
    check("empty",      empty,      cnt == 0);
    check("full",       full,       cnt > 64 - w_b);
    check("gen_active", gen_active, gact);
    check("gen_busy",   gen_busy,   dr);
    check("overflow",   overflow,   of);
    check("underflow",  underflow,  uf);
    last_of = overflow; last_uf = underflow; last_wb = int'(wr_bytes);
    @(posedge clk);
    #1;
    if (r) begin
      model_clear();
    end else if (flush) begin
      flush = 0;
    end else if (!up) begin
      if (lu) begin up = 1; gact = g; end
    end else if (!lu) begin
      flush = 1; up = 0; drain = 0; written = 0; readn = 0;
    end else begin
      readn += rr;
      if (we) written += w_b;
      if (!drain) begin
        if (g != gact) drain = 1;
      end else if (g == gact) begin
        drain = 0;
      end else if (written - readn == 0) begin
        gact = g; drain = 0;
      end
    end
  endtask

  int cur_gen;
  bit r_rst, r_lu, r_v, r_re;
  int r_rb;

  initial begin
    rst = 1'b1; linkup = 1'b0; gen = 3'd0; valid_pd = 1'b0; rd_en = 1'b0; rd_bytes = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // Gen1 basic: five 1-byte writes at consecutive addresses.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 0);
    check("t1_count", count, 5);
    check("t1_empty", empty, 0);

    // Gen3 fill: 16 writes fill the buffer, the 17th is dropped.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 2, 1, 0, 0);
    check("t2_overflow", last_of, 1);
    check("t2_count",    count,   64);
    check("t2_full",     full,    1);

    // Simultaneous pop and write near full.
    step(0, 1, 2, 0, 1, 2);
    step(0, 1, 2, 1, 1, 4);
    check("t3_overflow", last_of, 0);
    check("t3_count",    count,   62);
    check("t3_rd_addr",  rd_addr, 6);

    // Underflow: pop down to 2 bytes, then ask for 3.
    for (int i = 0; i < 15; i++) step(0, 1, 2, 0, 1, 4);
    step(0, 1, 2, 0, 1, 3);
    check("t4_underflow", last_uf, 1);
    check("t4_count",     count,   2);
    check("t4_rd_addr",   rd_addr, 2);

    // Gen change waits for the buffer to drain.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    check("t5_busy", gen_busy, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 2, 1, 1, 1);
    check("t5_gen_active", gen_active, 2);
    check("t5_busy_clear", gen_busy,   0);
    step(0, 1, 2, 1, 0, 0);
    check("t5_wr_bytes", last_wb, 4);

    // Link drop flushes, relink latches the current gen.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0, 0);
    check("t6_count_pre", count, 10);
    step(0, 0, 0, 0, 1, 1);
    check("t6_count",   count,   0);
    check("t6_empty",   empty,   1);
    check("t6_rd_addr", rd_addr, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    check("t6_gen_active", gen_active, 3);

    // Randomized traffic with occasional resets, link drops and gen changes.
    cur_gen = 2;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_lu  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 39) == 0) cur_gen = int'($urandom_range(0, 7));
      r_v   = ($urandom_range(0, 9) < 7);
      r_re  = ($urandom_range(0, 1) == 1);
      r_rb  = int'($urandom_range(0, 7));
      step(r_rst, r_lu, cur_gen, r_v, r_re, r_rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
